seq_barrel_shifter: RTL

- Multi-cycle ARM-style operand-2 shifter, one bit per cycle.
- Sits directly upstream of the ALU.
- Produces the ALU B operand (Shift_Out) and the shifter carry (Shift_Carry_Out) that logical ALU ops copy into NZCV.
- Start/done handshake; the execute controller holds the ALU op until done.

---
 rtl/seq_barrel_shifter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_barrel_shifter.sv
// rtl/seq_barrel_shifter.sv - ARM operand-2 shifter, one bit per cycle, start/done handshake
module seq_barrel_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] Shift_Data,
  input  logic [7:0]            Shift_Num,
  input  logic [2:0]            Shift_OP,
  input  logic                  CF,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Shift_Out,
  output logic                  Shift_Carry_Out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {M_LSL, M_LSR, M_ASR, M_ROR, M_RRX} mode_t;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d, load_mode;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  carry_q, carry_d;
  logic [5:0]            cnt_q, cnt_d, load_cnt;
  logic [4:0]            n5;
  logic                  reg_form;

  assign n5       = Shift_Num[4:0];
  assign reg_form = Shift_OP[0];

  // Step count chosen so every ARM boundary result falls out of plain stepping.
  always_comb begin
    load_mode = M_LSL;
    load_cnt  = 6'd0;
    case (Shift_OP[2:1])
      2'b00: begin
        load_mode = M_LSL;
        if (reg_form) load_cnt = (Shift_Num > 8'd33) ? 6'd33 : Shift_Num[5:0];
        else          load_cnt = {1'b0, n5};
      end
      2'b01: begin
        load_mode = M_LSR;
        if (reg_form) load_cnt = (Shift_Num > 8'd33) ? 6'd33 : Shift_Num[5:0];
        else          load_cnt = (n5 == 5'd0) ? 6'd32 : {1'b0, n5};
      end
      2'b10: begin
        load_mode = M_ASR;
        if (reg_form) load_cnt = (Shift_Num > 8'd32) ? 6'd32 : Shift_Num[5:0];
        else          load_cnt = (n5 == 5'd0) ? 6'd32 : {1'b0, n5};
      end
      default: begin
        load_mode = M_ROR;
        if (reg_form) begin
          if (Shift_Num == 8'd0) load_cnt = 6'd0;
          else if (n5 == 5'd0)   load_cnt = 6'd32;
          else                   load_cnt = {1'b0, n5};
        end else if (n5 == 5'd0) begin
          load_mode = M_RRX;
          load_cnt  = 6'd1;
        end else begin
          load_cnt = {1'b0, n5};
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = load_mode;
          data_d  = Shift_Data;
          carry_d = CF;
          cnt_d   = load_cnt;
          state_d = (load_cnt == 6'd0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 6'd1;
        case (mode_q)
          M_LSL: begin
            carry_d = data_q[DATA_WIDTH-1];
            data_d  = {data_q[DATA_WIDTH-2:0], 1'b0};
          end
          M_LSR: begin
            carry_d = data_q[0];
            data_d  = {1'b0, data_q[DATA_WIDTH-1:1]};
          end
          M_ASR: begin
            carry_d = data_q[0];
            data_d  = {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
          end
          M_ROR: begin
            carry_d = data_q[0];
            data_d  = {data_q[0], data_q[DATA_WIDTH-1:1]};
          end
          default: begin
            carry_d = data_q[0];
            data_d  = {carry_q, data_q[DATA_WIDTH-1:1]};
          end
        endcase
        if (cnt_q == 6'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_LSL;
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy            = (state_q == S_SHIFT);
  assign done            = (state_q == S_DONE);
  assign Shift_Out       = data_q;
  assign Shift_Carry_Out = carry_q;

endmodule
